// File: rtl/pe_sort_feeder.sv
// Input-side sequencer for pe_sort: clear pulse, per-word staging and enable,
// end-of-job marking, then waits for the sorter's end-of-job echo.
module pe_sort_feeder #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_num_words,
  input  logic              i_src_valid,
  input  logic [DATA_W-1:0] i_src_data,
  output logic              o_src_ready,
  output logic              o_sorter_clr,
  output logic              o_sorter_en,
  output logic [DATA_W-1:0] o_sorter_in,
  output logic              o_last_sort,
  input  logic              i_last_sort_o,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StLoad,
    StFire,
    StWaitLast
  } state_e;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e            r_state;
  state_e            w_state_next;
  logic [CNT_W-1:0]  r_num;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_last_idx;
  logic [DATA_W-1:0] r_sorter_in;
  logic              r_clr;
  logic              r_en;
  logic              r_last;
  logic              r_busy;
  logic              r_done;
  logic              w_done_next;
  logic              w_capture;
  logic              w_accept_job;
  logic              w_is_last;

  // r_num is never zero while a job runs, so this cannot underflow in use.
  assign w_last_idx = r_num - CntOne;
  assign w_is_last  = (r_cnt == w_last_idx);

  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    w_capture    = 1'b0;
    w_accept_job = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          if (i_num_words != '0) begin
            w_accept_job = 1'b1;
            w_state_next = StClr;
          end else begin
            w_done_next = 1'b1;
          end
        end
      end
      StClr: w_state_next = StLoad;
      StLoad: begin
        if (i_src_valid) begin
          w_capture    = 1'b1;
          w_state_next = StFire;
        end
      end
      StFire: w_state_next = w_is_last ? StWaitLast : StLoad;
      StWaitLast: begin
        if (i_last_sort_o) begin
          w_done_next  = 1'b1;
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_state     <= StIdle;
      r_num       <= '0;
      r_cnt       <= '0;
      r_sorter_in <= '0;
      r_clr       <= 1'b0;
      r_en        <= 1'b0;
      r_last      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept_job) begin
        r_num <= i_num_words;
        r_cnt <= '0;
      end
      if (r_state == StFire) begin
        r_cnt <= r_cnt + CntOne;
      end
      if (w_capture) begin
        r_sorter_in <= i_src_data;
      end
      // Outputs are registered from the next state so they align with it.
      r_clr  <= (w_state_next == StClr);
      r_en   <= (w_state_next == StFire);
      r_last <= w_capture && w_is_last;
      r_busy <= (w_state_next != StIdle);
      r_done <= w_done_next;
    end
  end

  assign o_src_ready  = (r_state == StLoad);
  assign o_sorter_clr = r_clr;
  assign o_sorter_en  = r_en;
  assign o_sorter_in  = r_sorter_in;
  assign o_last_sort  = r_last;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule

// File: tb/tb_pe_sort_feeder.sv
// Self-checking bench for pe_sort_feeder: directed latency checks plus
// randomized jobs scored against a word queue and per-job event counts.
module tb_pe_sort_feeder;

  localparam int DATA_W = 256;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [CNT_W-1:0]  num_words;
  logic              src_valid;
  logic [DATA_W-1:0] src_data;
  logic              src_ready;
  logic              sorter_clr;
  logic              sorter_en;
  logic [DATA_W-1:0] sorter_in;
  logic              last_sort;
  logic              last_sort_o;
  logic              busy;
  logic              done;

  int vectors = 0;
  int miscompares = 0;
  logic [DATA_W-1:0] m_sorter_in;

  always #5 clk = ~clk;

  pe_sort_feeder #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .i_sys_clk     (clk),
    .i_sys_rst     (rst),
    .i_start       (start),
    .i_num_words   (num_words),
    .i_src_valid   (src_valid),
    .i_src_data    (src_data),
    .o_src_ready   (src_ready),
    .o_sorter_clr  (sorter_clr),
    .o_sorter_en   (sorter_en),
    .o_sorter_in   (sorter_in),
    .o_last_sort   (last_sort),
    .i_last_sort_o (last_sort_o),
    .o_busy        (busy),
    .o_done        (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] rand_word();
    logic [DATA_W-1:0] w;
    for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; num_words = '0; src_valid = 1'b0; src_data = '0;
    last_sort_o = 1'b0;
    #3;
    vectors++;
    if ({src_ready, sorter_clr, sorter_en, last_sort, busy, done} !== 6'b0 ||
        sorter_in !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got flags=%b sorter_in=%h, want all 0",
               {src_ready, sorter_clr, sorter_en, last_sort, busy, done}, sorter_in);
    end
    tick(); tick();
    rst = 1'b0;
    m_sorter_in = '0;
    tick();
  endtask

  // One word, fixed byte pattern; cycle 0 is the cycle start is high.
  task automatic test_single_word();
    logic [DATA_W-1:0] pat;
    for (int i = 0; i < 32; i++) pat[i*8 +: 8] = 8'(i);
    start = 1'b1; num_words = 8'd1; src_valid = 1'b1; src_data = pat;
    tick();  // cycle 1
    start = 1'b0;
    vectors++;
    if (sorter_clr !== 1'b1 || busy !== 1'b1 || src_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL single_c1: clr=%b busy=%b ready=%b, want 1 1 0",
               sorter_clr, busy, src_ready);
    end
    tick();  // cycle 2
    vectors++;
    if (src_ready !== 1'b1 || sorter_clr !== 1'b0 || sorter_en !== 1'b0) begin
      miscompares++;
      $display("FAIL single_c2: ready=%b clr=%b en=%b, want 1 0 0",
               src_ready, sorter_clr, sorter_en);
    end
    tick();  // cycle 3
    src_valid = 1'b0;
    m_sorter_in = pat;
    vectors++;
    if (sorter_en !== 1'b1 || last_sort !== 1'b1 || sorter_in !== pat || src_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL single_c3: en=%b last=%b ready=%b in=%h, want 1 1 0 %h",
               sorter_en, last_sort, src_ready, sorter_in, pat);
    end
    tick(); tick(); tick();  // cycle 6
    last_sort_o = 1'b1;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b1 || sorter_en !== 1'b0) begin
      miscompares++;
      $display("FAIL single_c6: done=%b busy=%b en=%b, want 0 1 0", done, busy, sorter_en);
    end
    tick();  // cycle 7
    last_sort_o = 1'b0;
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || sorter_in !== pat) begin
      miscompares++;
      $display("FAIL single_c7: done=%b busy=%b in=%h, want 1 0 %h", done, busy, sorter_in, pat);
    end
    tick();
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL single_c8: done=%b, want 0", done);
    end
  endtask

  task automatic test_zero_words();
    int clrs = 0, ens = 0, busys = 0, dones = 0;
    start = 1'b1; num_words = '0;
    tick();
    start = 1'b0;
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_done: done=%b busy=%b, want 1 0", done, busy);
    end
    for (int i = 0; i < 4; i++) begin
      clrs += int'(sorter_clr); ens += int'(sorter_en); busys += int'(busy);
      tick();
      dones += int'(done);
    end
    vectors++;
    if (clrs != 0 || ens != 0 || busys != 0 || dones != 0) begin
      miscompares++;
      $display("FAIL zero_quiet: clr=%0d en=%0d busy=%0d extra_done=%0d, want 0 0 0 0",
               clrs, ens, busys, dones);
    end
  endtask

  // mode 0: valid always; 1: random valid; 2: 5-cycle stall before word 2.
  // inject: re-pulse start and last_sort_o while waiting for word 2.
  task automatic run_job(input int n, input int mode, input bit inject, input string tag);
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] w;
    int emitted = 0, clrs = 0, cyc = 0, last_en = -10, stall = 0, early_done = 0;
    bit injected = 1'b0;
    start = 1'b1; num_words = CNT_W'(n); src_valid = 1'b0;
    tick();
    start = 1'b0;
    cyc = 1;
    while (emitted < n && cyc < 4000) begin
      clrs += int'(sorter_clr);
      early_done += int'(done);
      if (sorter_en) begin
        vectors++;
        if (cyc - last_en < 2 || src_ready) begin
          miscompares++;
          $display("FAIL %s_spacing: gap=%0d ready=%b, want gap>=2 ready=0",
                   tag, cyc - last_en, src_ready);
        end
        last_en = cyc;
        m_sorter_in = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        emitted++;
        vectors++;
        if (sorter_in !== m_sorter_in || last_sort !== (emitted == n)) begin
          miscompares++;
          $display("FAIL %s_word%0d: in=%h last=%b, want %h %b",
                   tag, emitted, sorter_in, last_sort, m_sorter_in, emitted == n);
        end
      end else if (sorter_in !== m_sorter_in || last_sort !== 1'b0) begin
        vectors++;
        miscompares++;
        $display("FAIL %s_hold: in=%h last=%b, want %h 0", tag, sorter_in, last_sort, m_sorter_in);
      end
      case (mode)
        0: src_valid = 1'b1;
        1: src_valid = ($urandom_range(0, 2) != 0);
        default: begin
          src_valid = 1'b1;
          if (src_ready && emitted == 1 && stall < 5) begin
            src_valid = 1'b0;
            stall++;
          end
        end
      endcase
      w = rand_word();
      src_data = w;
      if (src_ready && src_valid) exp_q.push_back(w);
      if (inject && !injected && src_ready && emitted == 1) begin
        start = 1'b1; num_words = CNT_W'(3); last_sort_o = 1'b1;
        injected = 1'b1;
      end
      tick();
      cyc++;
      start = 1'b0; last_sort_o = 1'b0;
      if (mode == 2 && stall > 0 && stall < 5) begin
        vectors++;
        if (src_ready !== 1'b1 || sorter_en !== 1'b0) begin
          miscompares++;
          $display("FAIL %s_stall: ready=%b en=%b, want 1 0", tag, src_ready, sorter_en);
        end
      end
    end
    src_valid = 1'b0;
    vectors++;
    if (emitted != n || clrs != 1 || early_done != 0) begin
      miscompares++;
      $display("FAIL %s_job: words=%0d clr=%0d early_done=%0d, want %0d 1 0",
               tag, emitted, clrs, early_done, n);
    end
    for (int d = $urandom_range(0, 4); d > 0; d--) begin
      vectors++;
      if (busy !== 1'b1 || done !== 1'b0 || sorter_en !== 1'b0 || sorter_in !== m_sorter_in) begin
        miscompares++;
        $display("FAIL %s_wait: busy=%b done=%b en=%b, want 1 0 0", tag, busy, done, sorter_en);
      end
      tick();
    end
    last_sort_o = 1'b1;
    tick();
    last_sort_o = 1'b0;
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || sorter_in !== m_sorter_in) begin
      miscompares++;
      $display("FAIL %s_done: done=%b busy=%b, want 1 0", tag, done, busy);
    end
    tick();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_idle: done=%b busy=%b, want 0 0", tag, done, busy);
    end
  endtask

  task automatic test_reset_mid_job();
    int guard = 0, dones = 0;
    start = 1'b1; num_words = 8'd4; src_valid = 1'b1; src_data = rand_word();
    tick();
    start = 1'b0;
    while (!sorter_en && guard < 20) begin
      tick();
      guard++;
    end
    tick();  // word 2 being loaded
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({src_ready, sorter_clr, sorter_en, last_sort, busy, done} !== 6'b0 ||
        sorter_in !== '0 || guard >= 20) begin
      miscompares++;
      $display("FAIL midreset_outputs: flags=%b in=%h guard=%0d, want 0 0 <20",
               {src_ready, sorter_clr, sorter_en, last_sort, busy, done}, sorter_in, guard);
    end
    src_valid = 1'b0;
    tick();
    rst = 1'b0;
    m_sorter_in = '0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) last_sort_o = 1'b1;
      tick();
      last_sort_o = 1'b0;
      dones += int'(done) + int'(busy);
    end
    vectors++;
    if (dones != 0) begin
      miscompares++;
      $display("FAIL midreset_quiet: done/busy events=%0d, want 0", dones);
    end
    run_job(2, 0, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_zero_words();
    run_job(4, 0, 1'b0, "four");
    run_job(3, 2, 1'b0, "stall");
    run_job(5, 0, 1'b1, "ignore");
    for (int j = 0; j < 6; j++) run_job($urandom_range(1, 12), 1, 1'b0, "rand");
    run_job(255, 1, 1'b0, "max");
    test_reset_mid_job();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
